// File: rtl/instruction_fetch.sv
// Instruction memory + fetch: packs a byte-serial image into args_per-slot words, then streams them out.
// Latency: instr_valid rises the cycle after load_done; one instruction per cycle while instr_ready is high.
// Backpressure: instr/pc held while instr_valid && !instr_ready; load_ready is high only while loading.
module instruction_fetch #(
  parameter int w        = 8,
  parameter int args_per = 4,
  parameter int addr_w   = 8,
  parameter int halt_op  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [w-1:0]          load_data,
  output logic                  load_ready,
  input  logic                  load_done,
  output logic [args_per*w-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  jump_en,
  input  logic [addr_w-1:0]     jump_addr,
  output logic [addr_w-1:0]     pc,
  output logic [addr_w:0]       count,
  output logic [1:0]            state,
  output logic                  halted,
  output logic                  error
);
  localparam int idx_w = (args_per > 1) ? $clog2(args_per) : 1;
  localparam int depth = 1 << addr_w;
  localparam int iw    = args_per * w;
  localparam logic [addr_w:0]  full_cnt = {1'b1, {addr_w{1'b0}}};
  localparam logic [idx_w-1:0] last_idx = idx_w'(args_per - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t st, st_nxt;

  logic [iw-1:0]    mem [depth];
  logic [idx_w-1:0] idx, idx_upd;
  logic [addr_w:0]  count_upd, next_pc;
  logic [iw-1:0]    row0;
  logic             byte_acc, overflow, wr_en, handshake, stop, start_run;

  assign byte_acc  = load_valid && (st == S_LOAD);
  assign overflow  = byte_acc && (count == full_cnt);
  assign wr_en     = byte_acc && !overflow;
  assign handshake = (st == S_RUN) && instr_valid && instr_ready;
  assign next_pc   = jump_en ? {1'b0, jump_addr} : ({1'b0, pc} + (addr_w+1)'(1));
  assign stop      = (instr[w-1:0] == w'(halt_op)) || (next_pc >= count);
  assign start_run = (st == S_LOAD) && (st_nxt == S_RUN);

  // Slot pointer and instruction count as they will be after this cycle's byte.
  always_comb begin
    idx_upd   = idx;
    count_upd = count;
    if (wr_en) begin
      if (idx == last_idx) begin
        idx_upd   = '0;
        count_upd = count + (addr_w+1)'(1);
      end else begin
        idx_upd = idx + idx_w'(1);
      end
    end
  end

  // A single-instruction image may finish row 0 on the load_done cycle itself.
  always_comb begin
    row0 = mem[0];
    if (wr_en && (count == '0))
      row0[int'(idx)*w +: w] = load_data;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_LOAD: begin
        if (overflow)
          st_nxt = S_ERROR;
        else if (load_done) begin
          if (idx_upd != '0)
            st_nxt = S_ERROR;
          else if (count_upd == '0)
            st_nxt = S_ERROR;
          else
            st_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (handshake && stop)
          st_nxt = S_HALT;
      end
      default: st_nxt = st;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      st <= S_LOAD;
    else
      st <= st_nxt;
  end

  // Memory is deliberately left uninitialised; count=0 after reset forces a reload.
  always_ff @(posedge clock) begin
    if (wr_en)
      mem[count[addr_w-1:0]][int'(idx)*w +: w] <= load_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      count       <= '0;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      idx   <= idx_upd;
      count <= count_upd;
      if (start_run) begin
        pc          <= '0;
        instr       <= row0;
        instr_valid <= 1'b1;
      end else if (handshake) begin
        if (stop) begin
          instr_valid <= 1'b0;
        end else begin
          pc    <= next_pc[addr_w-1:0];
          instr <= mem[next_pc[addr_w-1:0]];
        end
      end
    end
  end

  assign load_ready = (st == S_LOAD);
  assign state      = st;
  assign halted     = (st == S_HALT);
  assign error      = (st == S_ERROR);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: load/run/jump/halt, backpressure, fault paths and mid-run reset.
module tb_instruction_fetch;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic        load_done = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic [7:0]  pc;
  logic [8:0]  count;
  logic [1:0]  state;
  logic        halted;
  logic        error;

  logic        s_load_valid = 1'b0;
  logic [7:0]  s_load_data = '0;
  logic        s_load_ready;
  logic        s_load_done = 1'b0;
  logic [31:0] s_instr;
  logic        s_instr_valid;
  logic        s_instr_ready = 1'b0;
  logic        s_jump_en = 1'b0;
  logic [1:0]  s_jump_addr = '0;
  logic [1:0]  s_pc;
  logic [2:0]  s_count;
  logic [1:0]  s_state;
  logic        s_halted;
  logic        s_error;

  int vectors = 0;
  int errs = 0;

  always #5 clock = ~clock;

  instruction_fetch #(.w(8), .args_per(4), .addr_w(8), .halt_op(0)) u_dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .pc(pc), .count(count), .state(state), .halted(halted), .error(error)
  );

  instruction_fetch #(.w(8), .args_per(4), .addr_w(2), .halt_op(0)) u_small (
    .clock(clock), .reset(reset),
    .load_valid(s_load_valid), .load_data(s_load_data), .load_ready(s_load_ready), .load_done(s_load_done),
    .instr(s_instr), .instr_valid(s_instr_valid), .instr_ready(s_instr_ready),
    .jump_en(s_jump_en), .jump_addr(s_jump_addr),
    .pc(s_pc), .count(s_count), .state(s_state), .halted(s_halted), .error(s_error)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic load_8byte_image();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
  endtask

  task automatic load_ops(input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2);
    send_byte(o0); send_byte(8'h11); send_byte(8'h12); send_byte(8'h13);
    send_byte(o1); send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
    send_byte(o2); send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
  endtask

  initial begin
    #1;
    apply_reset();
    check("rst_state", state, 2'd0);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_count", count, 9'd0);
    check("rst_pc", pc, 8'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_halted_error", {halted, error}, 2'b00);

    // Basic two-instruction image, free-running consumer.
    load_8byte_image();
    instr_ready = 1'b1;
    finish_load();
    check("t1_state_run", state, 2'd1);
    check("t1_count", count, 9'd2);
    check("t1_valid", instr_valid, 1'b1);
    check("t1_instr0", instr, 32'h04030201);
    check("t1_pc0", pc, 8'd0);
    check("t1_load_ready_low", load_ready, 1'b0);
    tick();
    check("t1_instr1", instr, 32'h08070605);
    check("t1_pc1", pc, 8'd1);
    tick();
    check("t1_halt_state", state, 2'd2);
    check("t1_halted", halted, 1'b1);
    check("t1_halt_pc", pc, 8'd1);
    check("t1_halt_valid", instr_valid, 1'b0);
    check("t1_halt_instr_held", instr, 32'h08070605);

    // Backpressure: stalled for 3 cycles, jump_en without handshake ignored.
    apply_reset();
    instr_ready = 1'b0;
    load_8byte_image();
    finish_load();
    jump_en = 1'b1;
    jump_addr = 8'd1;
    for (int i = 0; i < 3; i++) begin
      check("t2_stall_instr", instr, 32'h04030201);
      check("t2_stall_pc", pc, 8'd0);
      check("t2_stall_valid", instr_valid, 1'b1);
      tick();
    end
    jump_en = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("t2_adv_pc", pc, 8'd1);
    check("t2_adv_instr", instr, 32'h08070605);
    tick();
    check("t2_once_pc", pc, 8'd1);
    check("t2_once_state", state, 2'd1);

    // Jump from pc 0 to pc 2, then run off the end.
    apply_reset();
    load_ops(8'h05, 8'h06, 8'h07);
    instr_ready = 1'b1;
    finish_load();
    check("t3_count", count, 9'd3);
    check("t3_instr0", instr, 32'h13121105);
    jump_en = 1'b1;
    jump_addr = 8'd2;
    tick();
    jump_en = 1'b0;
    check("t3_jump_pc", pc, 8'd2);
    check("t3_jump_instr", instr, 32'h33323107);
    tick();
    check("t3_halt_state", state, 2'd2);
    check("t3_halt_pc", pc, 8'd2);

    // Jump beyond the image halts directly.
    apply_reset();
    load_ops(8'h05, 8'h06, 8'h07);
    finish_load();
    jump_en = 1'b1;
    jump_addr = 8'd9;
    tick();
    jump_en = 1'b0;
    check("t3b_halt_state", state, 2'd2);
    check("t3b_halt_pc", pc, 8'd0);
    check("t3b_valid", instr_valid, 1'b0);

    // halt_op in the middle of the image.
    apply_reset();
    load_ops(8'h05, 8'h00, 8'h07);
    finish_load();
    check("t4_pc0", pc, 8'd0);
    tick();
    check("t4_pc1", pc, 8'd1);
    check("t4_instr1", instr, 32'h23222100);
    tick();
    check("t4_halt_state", state, 2'd2);
    check("t4_halt_pc", pc, 8'd1);
    check("t4_halt_instr", instr, 32'h23222100);

    // load_done coinciding with the last byte of a single-instruction image.
    apply_reset();
    instr_ready = 1'b0;
    send_byte(8'h09); send_byte(8'h0a); send_byte(8'h0b);
    load_done = 1'b1;
    send_byte(8'h0c);
    load_done = 1'b0;
    check("t5_state", state, 2'd1);
    check("t5_count", count, 9'd1);
    check("t5_instr", instr, 32'h0c0b0a09);
    instr_ready = 1'b1;
    tick();
    check("t5_halt", state, 2'd2);

    // Partial instruction.
    apply_reset();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i));
    finish_load();
    check("f1_state", state, 2'd3);
    check("f1_error", error, 1'b1);
    check("f1_valid", instr_valid, 1'b0);
    tick();
    check("f1_sticky", state, 2'd3);
    check("f1_valid_later", instr_valid, 1'b0);
    check("f1_load_ready", load_ready, 1'b0);

    // Empty image.
    apply_reset();
    finish_load();
    check("f2_state", state, 2'd3);
    check("f2_error", error, 1'b1);
    check("f2_valid", instr_valid, 1'b0);

    // Overflow on the 4-deep instance.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      s_load_valid = 1'b1;
      s_load_data = 8'(i);
      tick();
    end
    check("f3_full_count", s_count, 3'd4);
    check("f3_full_state", s_state, 2'd0);
    s_load_data = 8'hee;
    tick();
    s_load_valid = 1'b0;
    check("f3_state", s_state, 2'd3);
    check("f3_error", s_error, 1'b1);
    check("f3_count", s_count, 3'd4);
    check("f3_valid", s_instr_valid, 1'b0);

    // Reset mid-run, then reload a different image.
    apply_reset();
    load_ops(8'h05, 8'h06, 8'h07);
    instr_ready = 1'b1;
    finish_load();
    tick();
    check("r_pc1", pc, 8'd1);
    reset = 1'b1;
    #1;
    check("r_state", state, 2'd0);
    check("r_valid", instr_valid, 1'b0);
    check("r_count", count, 9'd0);
    check("r_load_ready", load_ready, 1'b1);
    check("r_pc", pc, 8'd0);
    reset = 1'b0;
    instr_ready = 1'b0;
    send_byte(8'h0d); send_byte(8'h0e); send_byte(8'h0f); send_byte(8'h10);
    finish_load();
    check("r_reload_pc", pc, 8'd0);
    check("r_reload_instr", instr, 32'h100f0e0d);
    check("r_reload_count", count, 9'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
